// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, stage word layout and partial-product split helper
package mult_pkg;
  localparam int BW_DEFAULT = 16;
  localparam int PW = 2 * BW_DEFAULT;
  typedef struct packed {
    logic                  valid;
    logic                  signed_mode;
    logic [BW_DEFAULT-1:0] a;
    logic [BW_DEFAULT-1:0] b;
    logic [PW-1:0]         psum;
  } stage_word_t;
  function automatic int pps(input int bw, input int stages);
    return bw / stages;
  endfunction
endpackage

// File: rtl/pipelined_multiplier_pp_stage.sv
// mult_pp_stage: adds PPS shifted partial products (bits FIRST_BIT.. of a) to a running sum
//   a_slice  in   PPS    multiplicand bits handled by this stage
//   b        in   BW     multiplier, zero-extended before shifting
//   psum_in  in   2*BW   running sum from the previous stage
//   psum_out out  2*BW   running sum including this stage's partial products
module mult_pp_stage #(
  parameter int BW = 16,
  parameter int PPS = 4,
  parameter int FIRST_BIT = 0
) (
  input  logic [PPS-1:0]  a_slice,
  input  logic [BW-1:0]   b,
  input  logic [2*BW-1:0] psum_in,
  output logic [2*BW-1:0] psum_out
);
  always_comb begin
    psum_out = psum_in;
    for (int j = 0; j < PPS; j++)
      psum_out = psum_out + (a_slice[j] ? ({{BW{1'b0}}, b} << (FIRST_BIT + j)) : '0);
  end
endmodule

// File: rtl/pipelined_multiplier.sv
// pipelined_multiplier: STAGES-deep BW x BW signed/unsigned multiplier with valid/ready on both sides
//   CLK, RESETn (async, active-low)
//   in_valid/in_ready, A, B, signed_mode : operand side
//   out_valid/out_ready, out (2*BW)      : product side, out taken straight from the last stage register
//   acc_clr, acc_out (2*BW+8)            : running sum of delivered products, only with MULT_ACC_EN
module pipelined_multiplier
  import mult_pkg::*;
#(
  parameter int BW = BW_DEFAULT,
  parameter int STAGES = 4
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   A,
  input  logic [BW-1:0]   B,
  input  logic            signed_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*BW-1:0] out
`ifdef MULT_ACC_EN
  ,
  input  logic            acc_clr,
  output logic [2*BW+7:0] acc_out
`endif
);
  localparam int PRODW = 2 * BW;
  localparam int NPP = pps(BW, STAGES);
  typedef struct packed {
    logic             valid;
    logic             sm;
    logic [BW-1:0]    a;
    logic [BW-1:0]    b;
    logic [PRODW-1:0] psum;
  } stage_t;
  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t src [STAGES];
  logic [PRODW-1:0] sum_out [STAGES];
  logic [PRODW-1:0] corr;
  logic adv;
  assign out_valid = stage_q[STAGES-1].valid;
  assign out = stage_q[STAGES-1].psum;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  always_comb begin
    src[0] = '{valid: in_valid, sm: signed_mode, a: A, b: B, psum: '0};
    for (int k = 1; k < STAGES; k++) src[k] = stage_q[k-1];
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_pp_stage #(.BW(BW), .PPS(NPP), .FIRST_BIT(k * NPP)) u_pp (
      .a_slice (src[k].a[k*NPP +: NPP]),
      .b       (src[k].b),
      .psum_in (src[k].psum),
      .psum_out(sum_out[k])
    );
  end
  // Two's-complement fix-up of the unsigned product: subtract the sign-bit weights (mod 2^(2*BW))
  always_comb begin
    corr = (src[STAGES-1].sm && src[STAGES-1].a[BW-1] ? {src[STAGES-1].b, {BW{1'b0}}} : '0)
         + (src[STAGES-1].sm && src[STAGES-1].b[BW-1] ? {src[STAGES-1].a, {BW{1'b0}}} : '0);
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = src[k];
      stage_d[k].psum = sum_out[k];
    end
    stage_d[STAGES-1].psum = sum_out[STAGES-1] - corr;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end
`ifdef MULT_ACC_EN
  logic [PRODW+7:0] acc_q, acc_d, prod_ext;
  // Clear has priority over the old value, so a coinciding transfer loads the product alone
  always_comb begin
    prod_ext = {{8{stage_q[STAGES-1].sm & out[PRODW-1]}}, out};
    acc_d = acc_clr ? '0 : acc_q;
    acc_d = (out_valid && out_ready) ? acc_d + prod_ext : acc_d;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc_out = acc_q;
`endif
endmodule

// File: tb/tb_pipelined_multiplier.sv
// tb_pipelined_multiplier: directed table plus stall, reset and accumulator sequences
module tb_pipelined_multiplier;
  localparam int BW = 16;
  localparam int STAGES = 4;
  localparam int PW = 2 * BW;
  logic CLK = 0;
  logic RESETn;
  logic in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [BW-1:0] A, B;
  logic [PW-1:0] out;
`ifdef MULT_ACC_EN
  logic acc_clr;
  logic [PW+7:0] acc_out;
`endif
  int compared = 0;
  int mismatched = 0;
  pipelined_multiplier #(.BW(BW), .STAGES(STAGES)) dut (
    .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out)
`ifdef MULT_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc_out)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          sm;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t vt [8];
  function automatic logic [PW-1:0] model(logic [BW-1:0] a, logic [BW-1:0] b, logic sm);
    logic signed [PW-1:0] sa, sb;
    sa = {{BW{a[BW-1]}}, a};
    sb = {{BW{b[BW-1]}}, b};
    return sm ? PW'(sa * sb) : {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue_one(logic [BW-1:0] a, logic [BW-1:0] b, logic sm,
                           output logic [PW-1:0] res, output int lat);
    @(negedge CLK);
    A = a; B = b; signed_mode = sm; in_valid = 1;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    in_valid = 0;
    while (!out_valid && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    res = out;
  endtask
  logic [PW-1:0] res;
  int lat;
  logic [BW-1:0] sa [8], sb [8];
  logic ssm [8];
  logic [PW-1:0] q [$];
  initial begin
    vt[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vt[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vt[2] = '{16'h8000, 16'h0002, 1'b1, 32'hFFFF0000};
    vt[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vt[4] = '{16'h1234, 16'h0010, 1'b0, 32'h00012340};
    vt[5] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1};
    vt[6] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000};
    vt[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    RESETn = 0; in_valid = 0; A = 0; B = 0; signed_mode = 0; out_ready = 1;
`ifdef MULT_ACC_EN
    acc_clr = 0;
`endif
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge CLK);
    RESETn = 1;
    for (int i = 0; i < 8; i++) begin
      issue_one(vt[i].a, vt[i].b, vt[i].sm, res, lat);
      check($sformatf("vec%0d_out", i), 64'(res), 64'(vt[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
    end
    begin
      int c, idx, got;
      for (int i = 0; i < 8; i++) begin
        sa[i] = BW'($urandom); sb[i] = BW'($urandom); ssm[i] = 1'($urandom);
      end
      c = 0; idx = 0; got = 0;
      while (got < 8 && c < 100) begin
        @(negedge CLK);
        out_ready = !(c >= 6 && c <= 8);
        in_valid = idx < 8;
        A = idx < 8 ? sa[idx] : '0;
        B = idx < 8 ? sb[idx] : '0;
        signed_mode = idx < 8 ? ssm[idx] : 1'b0;
        #1;
        check("stream_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid) begin
          if (q.size() == 0) check("stream_spurious_valid", 64'(out_valid), 64'd0);
          else begin
            check("stream_out", 64'(out), 64'(q[0]));
            if (out_ready) begin
              void'(q.pop_front());
              got++;
            end
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(model(sa[idx], sb[idx], ssm[idx]));
          idx++;
        end
        c++;
      end
      @(negedge CLK);
      in_valid = 0; out_ready = 1;
      check("stream_received", 64'(got), 64'd8);
      check("stream_accepted", 64'(idx), 64'd8);
    end
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      A = 16'h0102 + 16'(i); B = 16'h0304; signed_mode = 0; in_valid = 1;
    end
    @(negedge CLK);
    in_valid = 0;
    @(negedge CLK);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    check("pre_reset_out", 64'(out), 64'(model(16'h0102, 16'h0304, 1'b0)));
    RESETn = 0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out", 64'(out), 64'd0);
    @(negedge CLK);
    RESETn = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("post_reset_no_stale", 64'(out_valid), 64'd0);
    end
    issue_one(16'hFFFE, 16'h0005, 1'b1, res, lat);
    check("post_reset_out", 64'(res), 64'hFFFFFFF6);
    check("post_reset_latency", 64'(lat), 64'(STAGES));
`ifdef MULT_ACC_EN
    @(negedge CLK);
    acc_clr = 1;
    @(negedge CLK);
    acc_clr = 0;
    check("acc_cleared", 64'(acc_out), 64'd0);
    issue_one(16'd3, 16'd4, 1'b1, res, lat);
    issue_one(16'hFFFB, 16'd2, 1'b1, res, lat);
    @(negedge CLK);
    check("acc_sum", 64'(acc_out), 64'd2);
    issue_one(16'd7, 16'd7, 1'b1, res, lat);
    acc_clr = 1;
    @(negedge CLK);
    acc_clr = 0;
    check("acc_clr_add", 64'(acc_out), 64'd49);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
